// File: rtl/mem_rr_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// mem_arb_pkg
//   Shared definitions for the node-memory round-robin arbiter: default bus
//   widths, the arbiter state encoding and the base byte addresses of the
//   node-memory regions the routing engines work on.
// ----------------------------------------------------------------------------
package mem_arb_pkg;

    localparam int ADDR_W_DEF   = 11;
    localparam int WORD_W_DEF   = 16;
    localparam int MAX_HOLD_DEF = 15;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } arb_state_t;

    // Node-memory region bases (byte addresses, words are big-endian).
    localparam logic [ADDR_W_DEF-1:0] KNOWN_SINKS    = 11'h008;
    localparam logic [ADDR_W_DEF-1:0] NEIGHBOR_ID    = 11'h048;
    localparam logic [ADDR_W_DEF-1:0] SINK_IDS       = 11'h248;
    localparam logic [ADDR_W_DEF-1:0] KNOWN_SINK_CNT = 11'h688;
    localparam logic [ADDR_W_DEF-1:0] NEIGHBOR_CNT   = 11'h68A;
    localparam logic [ADDR_W_DEF-1:0] BETTER_NB_CNT  = 11'h68C;
    localparam logic [ADDR_W_DEF-1:0] SINK_ID_CNT    = 11'h68E;

endpackage

// File: rtl/mem_rr_arbiter_if.sv
// ----------------------------------------------------------------------------
// mem_rr_arbiter_if
//   Requester-side bus of the node-memory arbiter.
//   req/lock/req_wr   N        per-requester request, lock, write-enable
//   req_addr          N*ADDR_W flat byte addresses, requester i at [i*ADDR_W +: ADDR_W]
//   req_wdata         N*WORD_W flat write data,     requester i at [i*WORD_W +: WORD_W]
//   gnt/ack/err       N        one-hot grant, completion pulse, error pulse
//   rdata             WORD_W   read data of the acked access
//   master: the routing engines; slave: the arbiter.
// ----------------------------------------------------------------------------
interface mem_rr_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int N      = 4,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int WORD_W = WORD_W_DEF
);

    logic [N-1:0]        req;
    logic [N-1:0]        lock;
    logic [N*ADDR_W-1:0] req_addr;
    logic [N-1:0]        req_wr;
    logic [N*WORD_W-1:0] req_wdata;
    logic [N-1:0]        gnt;
    logic [N-1:0]        ack;
    logic [N-1:0]        err;
    logic [WORD_W-1:0]   rdata;

    modport master (
        output req, lock, req_addr, req_wr, req_wdata,
        input  gnt, ack, err, rdata
    );

    modport slave (
        input  req, lock, req_addr, req_wr, req_wdata,
        output gnt, ack, err, rdata
    );

endinterface

// File: rtl/mem_rr_arbiter_rr_pick.sv
// ----------------------------------------------------------------------------
// rr_pick
//   Combinational N-way round-robin picker. Selects the first asserted
//   request at or after ptr, wrapping around to index 0.
//   req    in  N      request vector
//   ptr    in  IDX_W  highest-priority index this round
//   onehot out N      one-hot winner (0 when nothing requested)
//   idx    out IDX_W  winner index
//   any    out 1      at least one request asserted
// ----------------------------------------------------------------------------
module rr_pick #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     onehot,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    always_comb begin
        // NOTE: every output gets a default before any branch so no path
        // leaves a value unassigned and no latch is inferred.
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        // First pass covers ptr..N-1, second pass wraps to 0..ptr-1.
        for (int i = 0; i < N; i++) begin
            if (!any && req[i] && (IDX_W'(i) >= ptr)) begin
                any = 1'b1;
                idx = IDX_W'(i);
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!any && req[i]) begin
                any = 1'b1;
                idx = IDX_W'(i);
            end
        end
        for (int i = 0; i < N; i++) begin
            onehot[i] = any && (idx == IDX_W'(i));
        end
    end

endmodule

// File: rtl/mem_rr_arbiter.sv
// ----------------------------------------------------------------------------
// mem_rr_arbiter
//   Shares the single-port 2048x8 node memory (16-bit big-endian word port,
//   combinational read, write on posedge) between N routing engines.
//   Round-robin grant with an optional lock for atomic multi-word sequences.
//   clock         in   1       system clock, all logic on posedge
//   reset         in   1       synchronous, active-high
//   bus           slave       requester bus (req/lock/addr/wr/wdata, gnt/ack/err/rdata)
//   mem_address   out  ADDR_W to mem.address
//   mem_wr_en     out  1      to mem.wr_en
//   mem_data_in   out  WORD_W to mem.data_in
//   mem_data_out  in   WORD_W from mem.data_out
// ----------------------------------------------------------------------------
module mem_rr_arbiter
    import mem_arb_pkg::*;
#(
    parameter int N        = 4,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int WORD_W   = WORD_W_DEF,
    parameter int MAX_HOLD = MAX_HOLD_DEF
) (
    input  logic              clock,
    input  logic              reset,
    mem_rr_arbiter_if.slave   bus,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_wr_en,
    output logic [WORD_W-1:0] mem_data_in,
    input  logic [WORD_W-1:0] mem_data_out
);

    localparam int IDX_W  = (N > 1) ? $clog2(N) : 1;
    localparam int HOLD_W = $clog2(MAX_HOLD + 1);

    arb_state_t        state, state_next;
    logic [IDX_W-1:0]  owner, owner_next;
    logic [IDX_W-1:0]  rr_ptr, rr_ptr_next;
    logic [HOLD_W-1:0] hold_cnt, hold_cnt_next;
    logic [N-1:0]      gnt_q, gnt_next;
    logic [N-1:0]      ack_q, ack_next;
    logic [N-1:0]      err_q, err_next;
    logic [WORD_W-1:0] rdata_q, rdata_next;

    logic [N-1:0]      pick_onehot;
    logic [IDX_W-1:0]  pick_idx;
    logic              pick_any;

    logic              own_req;
    logic              own_lock;
    logic              own_wr;
    logic [ADDR_W-1:0] own_addr;
    logic [WORD_W-1:0] own_wdata;
    logic              addr_ok;
    logic              rel;

    assign bus.gnt   = gnt_q;
    assign bus.ack   = ack_q;
    assign bus.err   = err_q;
    assign bus.rdata = rdata_q;

    rr_pick #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req    (bus.req),
        .ptr    (rr_ptr),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    // Owner's request fields; other requesters are invisible while granted.
    always_comb begin
        own_req   = 1'b0;
        own_lock  = 1'b0;
        own_wr    = 1'b0;
        own_addr  = '0;
        own_wdata = '0;
        for (int i = 0; i < N; i++) begin
            if (owner == IDX_W'(i)) begin
                own_req   = bus.req[i];
                own_lock  = bus.lock[i];
                own_wr    = bus.req_wr[i];
                own_addr  = bus.req_addr[i*ADDR_W +: ADDR_W];
                own_wdata = bus.req_wdata[i*WORD_W +: WORD_W];
            end
        end
    end

    // Words are 16-bit, so only even byte addresses are legal (0x7FF is odd).
    assign addr_ok = ~own_addr[0];

    always_comb begin
        state_next    = state;
        owner_next    = owner;
        rr_ptr_next   = rr_ptr;
        hold_cnt_next = hold_cnt;
        gnt_next      = gnt_q;
        ack_next      = '0;
        err_next      = '0;
        rdata_next    = rdata_q;
        mem_address   = '0;
        mem_wr_en     = 1'b0;
        mem_data_in   = '0;
        rel           = 1'b0;

        case (state)
            IDLE: begin
                if (pick_any) begin
                    owner_next    = pick_idx;
                    gnt_next      = pick_onehot;
                    hold_cnt_next = '0;
                    state_next    = ACCESS;
                end
            end

            ACCESS: begin
                mem_address = own_addr;
                mem_data_in = own_wdata;
                if (own_req) begin
                    hold_cnt_next = '0;
                    if (addr_ok) begin
                        // A write still in flight when reset rises is dropped.
                        mem_wr_en = own_wr && !reset;
                        ack_next  = gnt_q;
                        if (!own_wr) begin
                            rdata_next = mem_data_out;
                        end
                    end else begin
                        err_next = gnt_q;
                    end
                    rel = !own_lock;
                end else if (hold_cnt == HOLD_W'(MAX_HOLD - 1)) begin
                    // Last allowed idle cycle: flag the owner and take the grant back.
                    err_next = gnt_q;
                    rel      = 1'b1;
                end else begin
                    hold_cnt_next = hold_cnt + HOLD_W'(1);
                    rel           = !own_lock;
                end

                if (rel) begin
                    state_next  = IDLE;
                    gnt_next    = '0;
                    // The releasing owner becomes lowest priority next round.
                    rr_ptr_next = (owner == IDX_W'(N - 1)) ? '0 : owner + IDX_W'(1);
                end
            end

            default: begin
                state_next = IDLE;
                gnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (reset) begin
            state    <= IDLE;
            owner    <= '0;
            rr_ptr   <= '0;
            hold_cnt <= '0;
            gnt_q    <= '0;
            ack_q    <= '0;
            err_q    <= '0;
            rdata_q  <= '0;
        end else begin
            state    <= state_next;
            owner    <= owner_next;
            rr_ptr   <= rr_ptr_next;
            hold_cnt <= hold_cnt_next;
            gnt_q    <= gnt_next;
            ack_q    <= ack_next;
            err_q    <= err_next;
            rdata_q  <= rdata_next;
        end
    end

endmodule
